kbd_event_fifo: RTL and testbench
=================================

# kbd_event_fifo

Downstream consumer of the PS/2 key decoder's 32-bit `cur_key` code. It turns code changes into discrete make/break key events and tracks the Shift, Ctrl and CapsLock modifiers. It optionally translates each event to ASCII and buffers the events in a show-ahead FIFO that the CPU's MMIO keyboard register drains.

## Interface
- `DEPTH`, default 16: FIFO entries. Power of two, at least 2.
- `clk` input 1: system clock.
- `clrn` input 1: synchronous active-low reset.
- `cur_key` input 32: decoder code.
  - `{24'h0, sc}` is make; `{24'hE0, sc}` is extended make.
  - `{24'hF0, sc}` is break; `{24'hE0F0, sc}` is extended break.
  - `0` means prefix in progress.
- `rd_en` input 1: pop head entry at the clock edge.
- `ovf_clr` input 1: clear the sticky overflow flag.
- `rd_data` output 24: head entry, valid while `!empty`.
  - [23] break, [22] ext, [21] shift, [20] ctrl, [19] caps, [18:16] zero, [15:8] scancode, [7:0] ascii.
- `empty` output 1: FIFO empty.
- `full` output 1: FIFO full.
- `count` output $clog2(DEPTH)+1: occupancy.
- `overflow` output 1: sticky flag, set when an event is dropped.

## Operation
- Stage 1 registers `cur_key` into `key_q`.
- Stage 2 compares `key_q` with `last_key`.
  - An event is detected when `key_q != 0` and `key_q != last_key`.
  - On an event, `last_key <= key_q`.
  - Zero codes and repeated identical codes (typematic repeat) generate nothing.
- Event decode:
  - `brk` = (`key_q[15:8]` == F0).
  - `ext` = (`key_q[15:8]` == E0) or (`key_q[23:16]` == E0).
  - `sc` = `key_q[7:0]`.
- Modifier update, applied on the event, before the entry is formed:
  - `lshift` (sc 12, non-ext) and `rshift` (sc 59, non-ext): set on make, clear on break.
  - `shift` = `lshift | rshift`.
  - `ctrl` (sc 14, ext or non-ext): set on make, clear on break.
  - `caps` (sc 58, non-ext): toggles on make; break is ignored.
- Entry fields:
  - Flags carry the post-update modifier state.
  - Modifier keys are enqueued like any other key, with ascii 00.
- Write path:
  - The entry is written when `!full`, or when `full && rd_en` in the same cycle (pop and push both occur, `count` unchanged, no overflow).
  - Otherwise the event is dropped and `overflow <= 1`.
- Read path:
  - Pop on `rd_en && !empty`.
  - `rd_en` while empty is ignored; `count` is not decremented.
- Pointers:
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `full`/`empty` are derived from `count`.
- `overflow` clears on `ovf_clr`. If a drop and `ovf_clr` occur in the same cycle, `overflow` stays 1.
- Reset values:
  - `key_q` = 0; `last_key` = 32'h0000001C, the decoder's reset code, so that code is never reported.
  - Modifiers 0, pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0.
  - `rd_data` follows the memory at pointer 0 and is don't-care while empty.
- Reset asserted mid-operation discards all buffered entries and modifier state within one edge.

## Timing
- Let `cur_key` first take a new value sampled at edge k.
  - Event detected in the cycle after k.
  - Entry written at edge k+1.
  - `empty` falls and `count` increments after edge k+1: two-cycle latency.
- `rd_data` is combinational from registered storage and head pointer: show-ahead, zero read latency.
- After a pop at edge n, the next entry appears on `rd_data` after edge n.
- At most one event per cycle. Back-to-back distinct codes on consecutive cycles each generate an event.

## Configuration
- `KBD_ASCII_EN` defined: `scancode_to_ascii` is instantiated and `rd_data[7:0]` carries the translation.
  - Letters a–z: uppercase when `shift ^ caps`.
  - Digits 0–9: shifted to `)!@#$%^&*(` when `shift`.
  - Space 29→20, Enter 5A→0D, Backspace 66→08.
  - Extended codes and all unlisted codes → 00.
  - Break entries carry the same ascii as the make would.
- `KBD_ASCII_EN` undefined: no ROM is built and `rd_data[7:0]` is constant 00. All other behaviour is identical.

## Structure
- `kbd_pkg` holds:
  - scancode constants (LSHIFT 12, RSHIFT 59, CTRL 14, CAPS 58, PREFIX_E0, PREFIX_F0, KBD_RESET_CODE 1C);
  - the packed struct `kbd_event_t` for the 24-bit entry.
- One sub-module, `scancode_to_ascii`: purely combinational, inputs `sc`, `ext`, `shift`, `caps`; output ascii. Compiled only under `KBD_ASCII_EN`.
- FIFO storage is inline; no separate FIFO module.

## Test plan
- Make/break of 'A':
  - Stimulus: `cur_key` 1C after reset, then 0, then F0_1C, then 1C.
  - Response: exactly two entries, `{brk=1,sc=1C,ascii=61}` then `{brk=0,sc=1C,ascii=61}`; the reset code alone gives nothing.
- Shift/caps:
  - Stimulus: make 12, make 1C, break 12, make 58, make 1C.
  - Response:
    - first 1C entry has shift=1, ascii 41;
    - caps entry has caps=1;
    - last 1C entry has ascii 41, shift=0.
  - Without `KBD_ASCII_EN`, every ascii field is 00.
- Extended:
  - Stimulus: E0_14, 0, E0F0_14.
  - Response: entries `{ext=1,ctrl=1,brk=0}` then `{ext=1,ctrl=0,brk=1}`.
- Overflow:
  - Stimulus: 17 distinct events with `rd_en`=0 (DEPTH 16).
  - Response: `full`=1, `count`=16, `overflow`=1, and the first 16 events read back in order.
  - `ovf_clr` then clears `overflow`.
- Full with simultaneous read/write:
  - Stimulus: FIFO full, event arrives on the same edge as `rd_en`.
  - Response: `count` stays 16, `overflow` stays 0, the new entry is at the tail.
- Reset mid-stream:
  - Stimulus: 5 entries buffered and shift held, then `clrn`=0 for one cycle.
  - Response: `empty`=1, `count`=0, shift=0 on the next event; `rd_en` while empty leaves `count` at 0.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and the FIFO entry layout for the keyboard event path.
//   - scancode constants for the modifier keys and PS/2 prefixes
//   - KBD_RESET_CODE: code the decoder presents out of reset
//   - kbd_event_t: 24-bit FIFO entry
package kbd_pkg;

    localparam int unsigned KEY_W   = 32;
    localparam int unsigned ASCII_W = 8;

    localparam logic [7:0] LSHIFT    = 8'h12;
    localparam logic [7:0] RSHIFT    = 8'h59;
    localparam logic [7:0] CTRL      = 8'h14;
    localparam logic [7:0] CAPS      = 8'h58;
    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;

    localparam logic [KEY_W-1:0] KBD_RESET_CODE = 32'h0000_001C;

    // FIFO entry, MSB first: [23] brk, [22] ext, [21] shift, [20] ctrl,
    // [19] caps, [18:16] zero, [15:8] scancode, [7:0] ascii
    typedef struct packed {
        logic               brk;
        logic               ext;
        logic               shift;
        logic               ctrl;
        logic               caps;
        logic [2:0]         rsvd;
        logic [7:0]         sc;
        logic [ASCII_W-1:0] ascii;
    } kbd_event_t;

endpackage

// File: rtl/kbd_event_fifo_scancode_to_ascii.sv
// scancode_to_ascii: combinational set-2 scancode to ASCII translation.
// Built only when KBD_ASCII_EN is defined.
//   sc    in  8  scancode
//   ext   in  1  extended (E0) code; always translates to 00
//   shift in  1  either shift held
//   caps  in  1  caps-lock state
//   ascii out 8  translated character, 00 when unmapped
`ifdef KBD_ASCII_EN
module scancode_to_ascii
    import kbd_pkg::*;
(
    input  logic [7:0]         sc,
    input  logic               ext,
    input  logic               shift,
    input  logic               caps,
    output logic [ASCII_W-1:0] ascii
);

    logic [7:0] base;
    logic       is_alpha;
    logic       is_digit;

    // Shifted glyphs on the number row
    function automatic logic [7:0] shift_digit(input logic [7:0] d);
        logic [7:0] r;
        case (d)
            8'h30:   r = 8'h29; // 0 -> )
            8'h31:   r = 8'h21; // 1 -> !
            8'h32:   r = 8'h40; // 2 -> @
            8'h33:   r = 8'h23; // 3 -> #
            8'h34:   r = 8'h24; // 4 -> $
            8'h35:   r = 8'h25; // 5 -> %
            8'h36:   r = 8'h5E; // 6 -> ^
            8'h37:   r = 8'h26; // 7 -> &
            8'h38:   r = 8'h2A; // 8 -> *
            8'h39:   r = 8'h28; // 9 -> (
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Unshifted character lookup
    always_comb begin
        base     = 8'h00;
        is_alpha = 1'b0;
        is_digit = 1'b0;
        case (sc)
            8'h1C: begin base = 8'h61; is_alpha = 1'b1; end
            8'h32: begin base = 8'h62; is_alpha = 1'b1; end
            8'h21: begin base = 8'h63; is_alpha = 1'b1; end
            8'h23: begin base = 8'h64; is_alpha = 1'b1; end
            8'h24: begin base = 8'h65; is_alpha = 1'b1; end
            8'h2B: begin base = 8'h66; is_alpha = 1'b1; end
            8'h34: begin base = 8'h67; is_alpha = 1'b1; end
            8'h33: begin base = 8'h68; is_alpha = 1'b1; end
            8'h43: begin base = 8'h69; is_alpha = 1'b1; end
            8'h3B: begin base = 8'h6A; is_alpha = 1'b1; end
            8'h42: begin base = 8'h6B; is_alpha = 1'b1; end
            8'h4B: begin base = 8'h6C; is_alpha = 1'b1; end
            8'h3A: begin base = 8'h6D; is_alpha = 1'b1; end
            8'h31: begin base = 8'h6E; is_alpha = 1'b1; end
            8'h44: begin base = 8'h6F; is_alpha = 1'b1; end
            8'h4D: begin base = 8'h70; is_alpha = 1'b1; end
            8'h15: begin base = 8'h71; is_alpha = 1'b1; end
            8'h2D: begin base = 8'h72; is_alpha = 1'b1; end
            8'h1B: begin base = 8'h73; is_alpha = 1'b1; end
            8'h2C: begin base = 8'h74; is_alpha = 1'b1; end
            8'h3C: begin base = 8'h75; is_alpha = 1'b1; end
            8'h2A: begin base = 8'h76; is_alpha = 1'b1; end
            8'h1D: begin base = 8'h77; is_alpha = 1'b1; end
            8'h22: begin base = 8'h78; is_alpha = 1'b1; end
            8'h35: begin base = 8'h79; is_alpha = 1'b1; end
            8'h1A: begin base = 8'h7A; is_alpha = 1'b1; end
            8'h45: begin base = 8'h30; is_digit = 1'b1; end
            8'h16: begin base = 8'h31; is_digit = 1'b1; end
            8'h1E: begin base = 8'h32; is_digit = 1'b1; end
            8'h26: begin base = 8'h33; is_digit = 1'b1; end
            8'h25: begin base = 8'h34; is_digit = 1'b1; end
            8'h2E: begin base = 8'h35; is_digit = 1'b1; end
            8'h36: begin base = 8'h36; is_digit = 1'b1; end
            8'h3D: begin base = 8'h37; is_digit = 1'b1; end
            8'h3E: begin base = 8'h38; is_digit = 1'b1; end
            8'h46: begin base = 8'h39; is_digit = 1'b1; end
            8'h29: base = 8'h20;
            8'h5A: base = 8'h0D;
            8'h66: base = 8'h08;
            default: base = 8'h00;
        endcase
    end

    // Apply modifiers; letters honour caps, digits only shift
    always_comb begin
        ascii = 8'h00;
        if (ext) begin
            ascii = 8'h00;
        end else if (is_alpha) begin
            ascii = (shift ^ caps) ? (base - 8'h20) : base;
        end else if (is_digit) begin
            ascii = shift ? shift_digit(base) : base;
        end else begin
            ascii = base;
        end
    end

endmodule
`endif

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: turns PS/2 decoder code changes into make/break events,
// tracks Shift/Ctrl/CapsLock and buffers events in a show-ahead FIFO.
// Optional macro KBD_ASCII_EN builds scancode_to_ascii; otherwise ascii = 00.
//   clk      in   1  system clock
//   clrn     in   1  synchronous active-low reset
//   cur_key  in  32  decoder code (0 = prefix in progress)
//   rd_en    in   1  pop head entry
//   ovf_clr  in   1  clear sticky overflow
//   rd_data  out 24  head entry (kbd_event_t layout), valid while !empty
//   empty    out  1  FIFO empty
//   full     out  1  FIFO full
//   count    out  clog2(DEPTH)+1  occupancy
//   overflow out  1  sticky, set when an event is dropped
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [31:0]              cur_key,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [23:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] last_q, last_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic             ctrl_q, ctrl_d;
    logic             caps_q, caps_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    kbd_event_t       mem_q [DEPTH];

    logic             evt;
    logic             brk;
    logic             ext;
    logic [7:0]       sc;
    logic             push;
    logic             pop;
    logic             drop;
    logic [7:0]       ascii_c;
    kbd_event_t       entry;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Event decode from the registered code
    always_comb begin
        evt = (key_q != '0) && (key_q != last_q);
        brk = (key_q[15:8] == PREFIX_F0);
        ext = (key_q[15:8] == PREFIX_E0) || (key_q[23:16] == PREFIX_E0);
        sc  = key_q[7:0];
    end

`ifdef KBD_ASCII_EN
    // Translation uses post-update modifiers so breaks match their makes
    scancode_to_ascii u_ascii (
        .sc    (sc),
        .ext   (ext),
        .shift (lshift_d | rshift_d),
        .caps  (caps_d),
        .ascii (ascii_c)
    );
`else
    assign ascii_c = 8'h00;
`endif

    // Next-state: modifiers, entry, FIFO pointers and flags
    always_comb begin
        key_d    = cur_key;
        last_d   = last_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        ctrl_d   = ctrl_q;
        caps_d   = caps_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (evt) begin
            last_d = key_q;
            if (!ext && sc == LSHIFT) lshift_d = !brk;
            if (!ext && sc == RSHIFT) rshift_d = !brk;
            if (sc == CTRL)           ctrl_d   = !brk;
            if (!ext && sc == CAPS && !brk) caps_d = !caps_q;
        end

        entry.brk   = brk;
        entry.ext   = ext;
        entry.shift = lshift_d | rshift_d;
        entry.ctrl  = ctrl_d;
        entry.caps  = caps_d;
        entry.rsvd  = 3'b000;
        entry.sc    = sc;
        entry.ascii = ascii_c;

        // When full, a same-cycle pop frees the slot being written
        pop  = rd_en && !empty;
        push = evt && (!full || rd_en);
        drop = evt && !push;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A drop wins over a clear in the same cycle
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            key_q    <= '0;
            last_q   <= KBD_RESET_CODE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            ctrl_q   <= 1'b0;
            caps_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            key_q    <= key_d;
            last_q   <= last_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            ctrl_q   <= ctrl_d;
            caps_q   <= caps_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (clrn && push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

endmodule

// File: tb/tb_kbd_event_fifo.sv
// tb_kbd_event_fifo: directed self-checking bench for kbd_event_fifo.
// Honors KBD_ASCII_EN the same way as the design.
module tb_kbd_event_fifo;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] cur_key;
    logic        rd_en;
    logic        ovf_clr;
    logic [23:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

`ifdef KBD_ASCII_EN
    localparam bit ASC_ON = 1'b1;
`else
    localparam bit ASC_ON = 1'b0;
`endif

    kbd_event_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .cur_key  (cur_key),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [7:0] v);
        return ASC_ON ? v : 8'h00;
    endfunction

    function automatic logic [23:0] mk(input logic b, input logic e, input logic s,
                                       input logic c, input logic k,
                                       input logic [7:0] sc, input logic [7:0] a);
        return {b, e, s, c, k, 3'b000, sc, a};
    endfunction

    // All tasks start and end at a falling edge
    task automatic send(input logic [31:0] code);
        cur_key = code;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [23:0] exp);
        chk(tag, {8'h0, rd_data}, {8'h0, exp});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        clrn    = 1'b0;
        cur_key = 32'h0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        idle(2);
        clrn = 1'b1;

        chk("rst_empty", {31'h0, empty}, 32'd1);
        chk("rst_full", {31'h0, full}, 32'd0);
        chk("rst_count", {27'h0, count}, 32'd0);
        chk("rst_ovf", {31'h0, overflow}, 32'd0);

        // Make/break of 'A'; reset code alone is silent
        send(32'h1C);
        idle(2);
        chk("resetcode_silent", {31'h0, empty}, 32'd1);
        send(32'h0);
        send(32'hF01C);
        send(32'h1C);
        send(32'h0);
        idle(2);
        chk("a_count", {27'h0, count}, 32'd2);
        pop_chk("a_break", mk(1, 0, 0, 0, 0, 8'h1C, asc(8'h61)));
        pop_chk("a_make", mk(0, 0, 0, 0, 0, 8'h1C, asc(8'h61)));
        chk("a_empty", {31'h0, empty}, 32'd1);

        // Shift / caps
        send(32'h12);
        send(32'h1C);
        send(32'hF012);
        send(32'h58);
        send(32'h1C);
        send(32'hF058);
        send(32'h58);
        send(32'h0);
        idle(2);
        chk("sc_count", {27'h0, count}, 32'd7);
        pop_chk("sc_shift_mk", mk(0, 0, 1, 0, 0, 8'h12, 8'h00));
        pop_chk("sc_upper_a", mk(0, 0, 1, 0, 0, 8'h1C, asc(8'h41)));
        pop_chk("sc_shift_brk", mk(1, 0, 0, 0, 0, 8'h12, 8'h00));
        pop_chk("sc_caps_on", mk(0, 0, 0, 0, 1, 8'h58, 8'h00));
        pop_chk("sc_caps_a", mk(0, 0, 0, 0, 1, 8'h1C, asc(8'h41)));
        pop_chk("sc_caps_brk", mk(1, 0, 0, 0, 1, 8'h58, 8'h00));
        pop_chk("sc_caps_off", mk(0, 0, 0, 0, 0, 8'h58, 8'h00));

        // Extended ctrl
        send(32'hE014);
        send(32'h0);
        send(32'hE0F014);
        send(32'h0);
        idle(2);
        pop_chk("ext_mk", mk(0, 1, 0, 1, 0, 8'h14, 8'h00));
        pop_chk("ext_brk", mk(1, 1, 0, 0, 0, 8'h14, 8'h00));

        // Overflow: 17 distinct events, no reads
        for (int i = 0; i < 17; i++) send(32'h70 + i);
        send(32'h0);
        idle(2);
        chk("ovf_full", {31'h0, full}, 32'd1);
        chk("ovf_count", {27'h0, count}, 32'd16);
        chk("ovf_flag", {31'h0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'h0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("ovf_rd%0d", i), mk(0, 0, 0, 0, 0, 8'(8'h70 + i), 8'h00));
        chk("ovf_drained", {31'h0, empty}, 32'd1);

        // Full with simultaneous pop and push
        for (int i = 0; i < 16; i++) send(32'h90 + i);
        send(32'h0);
        idle(2);
        chk("fw_full", {31'h0, full}, 32'd1);
        chk("fw_head", {8'h0, rd_data}, {8'h0, mk(0, 0, 0, 0, 0, 8'h90, 8'h00)});
        cur_key = 32'hA0;
        idle(1);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        chk("fw_count", {27'h0, count}, 32'd16);
        chk("fw_ovf", {31'h0, overflow}, 32'd0);
        // Drop coinciding with clear keeps the flag set
        cur_key = 32'hA1;
        idle(1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("drop_vs_clr", {31'h0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("clr_after", {31'h0, overflow}, 32'd0);
        send(32'h0);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("fw_rd%0d", i), mk(0, 0, 0, 0, 0, 8'(8'h90 + i), 8'h00));
        pop_chk("fw_tail", mk(0, 0, 0, 0, 0, 8'hA0, 8'h00));
        chk("fw_empty", {31'h0, empty}, 32'd1);

        // Reset mid-stream
        send(32'h12);
        send(32'h71);
        send(32'h72);
        send(32'h73);
        send(32'h74);
        send(32'h0);
        idle(2);
        chk("rm_count5", {27'h0, count}, 32'd5);
        clrn = 1'b0;
        idle(1);
        clrn = 1'b1;
        chk("rm_empty", {31'h0, empty}, 32'd1);
        chk("rm_count0", {27'h0, count}, 32'd0);
        send(32'h75);
        send(32'h0);
        idle(2);
        pop_chk("rm_noshift", mk(0, 0, 0, 0, 0, 8'h75, 8'h00));
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        chk("rd_empty_cnt", {27'h0, count}, 32'd0);
        chk("rd_empty_flag", {31'h0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
